// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - UART request/echo loader writing framed blocks into one of NUM_TARGETS memories
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module uart_mem_loader #(
  parameter int         ADDR_W      = 14,
  parameter int         NUM_TARGETS = 3,
  parameter logic [7:0] REQ_BYTE    = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             rx_data,
  input  logic                   rx_done,
  input  logic                   tx_done,
  output logic [7:0]             tx_data,
  output logic                   tx_wr,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [7:0]             mem_data,
  output logic [NUM_TARGETS-1:0] mem_we,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            byte_count
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_TX, WAIT_RX, HDR, WRITE, DONE} state_t;
  typedef enum logic [2:0] {PH_TGT, PH_LEN_LO, PH_LEN_HI, PH_DATA, PH_CSUM, PH_END} phase_t;

  state_t     state, state_nx;
  phase_t     phase;
  phase_t     after_data;
  logic       start_q;
  logic       rx_pend;
  logic [7:0] rx_hold;
  logic [7:0] target;
  logic [7:0] len_lo;
  logic [15:0] len;
  logic       target_ok;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign after_data = PH_CSUM;
`else
  assign after_data = PH_END;
`endif

  assign target_ok = int'(target) < NUM_TARGETS;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_wr    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    mem_we   = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_q) state_nx = REQ;
      end
      REQ: begin
        tx_wr    = 1'b1;
        state_nx = WAIT_TX;
      end
      WAIT_TX: if (tx_done) state_nx = (phase == PH_END) ? DONE : WAIT_RX;
      WAIT_RX: if (rx_pend) state_nx = (phase == PH_DATA) ? WRITE : HDR;
      HDR:     state_nx = REQ;
      WRITE: begin
        if (target_ok) mem_we = NUM_TARGETS'(1) << target;
        state_nx = REQ;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q    <= 1'b0;
      rx_pend    <= 1'b0;
      rx_hold    <= 8'h00;
      tx_data    <= 8'h00;
      mem_addr   <= '0;
      mem_data   <= 8'h00;
      err        <= 1'b0;
      byte_count <= 16'd0;
      phase      <= PH_TGT;
      target     <= 8'h00;
      len_lo     <= 8'h00;
      len        <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      // start is registered so it is only ever seen while idle
      start_q <= start && (state == IDLE);
      if (rx_done) rx_hold <= rx_data;
      if (rx_done)            rx_pend <= 1'b1;
      else if (state == REQ)  rx_pend <= 1'b0;

      case (state)
        IDLE: if (start_q) begin
          tx_data    <= REQ_BYTE;
          err        <= 1'b0;
          byte_count <= 16'd0;
          mem_addr   <= '0;
          phase      <= PH_TGT;
`ifdef LOADER_CHECKSUM_EN
          csum       <= 8'h00;
`endif
        end
        WAIT_RX: if (rx_pend) begin
          tx_data <= rx_hold;
          if (phase == PH_DATA) mem_data <= rx_hold;
        end
        // tx_data holds the byte just received, so header fields are taken from it
        HDR: case (phase)
          PH_TGT: begin
            target <= tx_data;
            if (int'(tx_data) >= NUM_TARGETS) err <= 1'b1;
            phase <= PH_LEN_LO;
          end
          PH_LEN_LO: begin
            len_lo <= tx_data;
            phase  <= PH_LEN_HI;
          end
          PH_LEN_HI: begin
            len   <= {tx_data, len_lo};
            phase <= ({tx_data, len_lo} == 16'd0) ? after_data : PH_DATA;
          end
`ifdef LOADER_CHECKSUM_EN
          PH_CSUM: begin
            if (tx_data != csum) err <= 1'b1;
            phase <= PH_END;
          end
`endif
          default: phase <= PH_END;
        endcase
        WRITE: begin
          mem_addr   <= mem_addr + ADDR_W'(1);
          byte_count <= byte_count + 16'd1;
`ifdef LOADER_CHECKSUM_EN
          csum       <= csum + mem_data;
`endif
          if (byte_count + 16'd1 == len) phase <= after_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - frame table plus random frames checked against a queue-based host model
`timescale 1ns/1ps
module tb_uart_mem_loader;
  localparam int         AW  = 4;
  localparam int         NT  = 3;
  localparam logic [7:0] REQ = 8'h5A;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic clk = 0, rst = 1, start = 0, rx_done = 0, tx_done = 0;
  logic [7:0] rx_data = 0;
  logic [7:0] tx_data, mem_data;
  logic tx_wr, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [NT-1:0] mem_we;
  logic [15:0] byte_count;

  uart_mem_loader #(.ADDR_W(AW), .NUM_TARGETS(NT), .REQ_BYTE(REQ)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_done(rx_done),
    .tx_done(tx_done), .tx_data(tx_data), .tx_wr(tx_wr), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .busy(busy), .done(done), .err(err),
    .byte_count(byte_count));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic [NT-1:0] we; logic [AW-1:0] addr; logic [7:0] data;} wr_t;
  typedef struct {
    logic [7:0] tgt; int n; logic [7:0] d0; logic [7:0] step; logic [7:0] cdelta;
    int coinc; bit sbusy; bit exp_err;
  } vec_t;

  int n_pass = 0, n_tot = 0;
  logic [7:0] mon_tx[$];
  int mon_txc[$], mon_wc[$], rxc[$];
  wr_t mon_w[$];
  int done_n, done_cyc, start_cyc, last_txd;
  logic err_at_done, busy_at_done, busy_after, prev_done = 0;
  logic [15:0] bc_at_done;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (tx_wr) begin mon_tx.push_back(tx_data); mon_txc.push_back(cyc); end
    if (mem_we != '0) begin mon_w.push_back({mem_we, mem_addr, mem_data}); mon_wc.push_back(cyc); end
    if (done) begin
      done_n++; done_cyc = cyc; err_at_done = err; bc_at_done = byte_count; busy_at_done = busy;
    end
    if (prev_done) busy_after = busy;
    prev_done = done;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx_data"}, tx_data == 8'h00, tx_data, 0);
    chk({tag, "_tx_wr"}, tx_wr == 1'b0, tx_wr, 0);
    chk({tag, "_mem_addr"}, mem_addr == '0, mem_addr, 0);
    chk({tag, "_mem_data"}, mem_data == 8'h00, mem_data, 0);
    chk({tag, "_mem_we"}, mem_we == '0, mem_we, 0);
    chk({tag, "_busy"}, busy == 1'b0, busy, 0);
    chk({tag, "_done"}, done == 1'b0, done, 0);
    chk({tag, "_err"}, err == 1'b0, err, 0);
    chk({tag, "_byte_count"}, byte_count == 16'd0, byte_count, 0);
  endtask

  // UART side: answers each tx_wr with tx_done, then supplies the next frame byte
  task automatic host(input logic [7:0] fb[$], input int coinc, input bit sbusy, input int stop);
    mon_tx = {}; mon_txc = {}; mon_w = {}; mon_wc = {}; rxc = {};
    done_n = 0; busy_after = 1'bx;
    start = 1; start_cyc = cyc; @(negedge clk); start = 0;
    for (int k = 0; k <= fb.size(); k++) begin
      for (int g = 0; g < 100 && !tx_wr; g++) @(negedge clk);
      if (!tx_wr) begin chk("host_tx_wr_timeout", 0, k, fb.size()); return; end
      if (k == stop) return;
      if (sbusy && k == 5) start = 1;
      if (k < fb.size() && k == coinc) begin rx_data = fb[k]; rx_done = 1; rxc.push_back(cyc); end
      @(negedge clk);
      rx_done = 0; start = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      tx_done = 1; last_txd = cyc; @(negedge clk); tx_done = 0;
      if (k < fb.size() && k != coinc) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rx_data = fb[k]; rx_done = 1; rxc.push_back(cyc); @(negedge clk); rx_done = 0;
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] tgt, input logic [7:0] d[$], input logic [7:0] cdelta,
                           input int coinc, input bit sbusy, input bit exp_err);
    logic [7:0] fb[$], ex_tx[$];
    wr_t ex_w[$];
    logic [15:0] n16;
    logic [7:0] sum;
    int bad;
    bit lat_ok;
    n16 = 16'(d.size());
    sum = 8'h00;
    fb = {tgt, n16[7:0], n16[15:8]};
    foreach (d[i]) begin fb.push_back(d[i]); sum = sum + d[i]; end
    if (CS) fb.push_back(sum + cdelta);
    host(fb, coinc, sbusy, -1);
    for (int g = 0; g < 60 && done_n == 0; g++) @(negedge clk);
    repeat (2) @(negedge clk);

    ex_tx = {REQ};
    foreach (fb[i]) ex_tx.push_back(fb[i]);
    bad = (mon_tx.size() == ex_tx.size()) ? -1 : 0;
    foreach (ex_tx[i]) if (bad < 0 && i < mon_tx.size() && mon_tx[i] != ex_tx[i]) bad = i;
    chk("tx_echo_seq", bad < 0, (bad >= 0 && bad < mon_tx.size()) ? mon_tx[bad] : mon_tx.size(),
        (bad >= 0) ? ex_tx[bad] : ex_tx.size());

    if (int'(tgt) < NT)
      foreach (d[i]) ex_w.push_back({NT'(1) << tgt, AW'(i), d[i]});
    bad = (mon_w.size() == ex_w.size()) ? -1 : 0;
    foreach (ex_w[i]) if (bad < 0 && i < mon_w.size() && mon_w[i] != ex_w[i]) bad = i;
    chk("mem_write_seq", bad < 0, (bad >= 0 && bad < mon_w.size()) ? mon_w[bad] : mon_w.size(),
        (bad >= 0 && bad < ex_w.size()) ? ex_w[bad] : ex_w.size());

    chk("done_pulses", done_n == 1, done_n, 1);
    chk("err_at_done", err_at_done === exp_err, err_at_done, exp_err);
    chk("byte_count", bc_at_done === n16, bc_at_done, n16);
    chk("done_timing", done_cyc == last_txd + 1 && busy_at_done === 1'b1 && busy_after === 1'b0,
        done_cyc, last_txd + 1);

    lat_ok = (mon_txc.size() == fb.size() + 1) && (rxc.size() == fb.size());
    if (lat_ok) begin
      if (mon_txc[0] != start_cyc + 2) lat_ok = 0;
      foreach (rxc[k]) if (k != coinc && mon_txc[k + 1] != rxc[k] + 3) lat_ok = 0;
      if (mon_wc.size() == ex_w.size())
        foreach (mon_wc[j]) if (3 + j != coinc && mon_wc[j] != rxc[3 + j] + 2) lat_ok = 0;
    end
    chk("latency", lat_ok, mon_txc.size() > 0 ? mon_txc[0] : -1, start_cyc + 2);

    if (done_n != 1) begin rst = 1; @(negedge clk); rst = 0; @(negedge clk); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    logic [7:0] d[$], fb[$];
    tbl[0] = '{8'h00, 4,  8'h11, 8'h11, 8'h00, -1, 1'b0, 1'b0};
    tbl[1] = '{8'h05, 2,  8'h01, 8'h01, 8'h00, -1, 1'b0, 1'b1};
    tbl[2] = '{8'h01, 3,  8'h10, 8'h10, 8'h01, -1, 1'b0, CS};
    tbl[3] = '{8'h01, 3,  8'h10, 8'h10, 8'h00, -1, 1'b0, 1'b0};
    tbl[4] = '{8'h02, 0,  8'h00, 8'h00, 8'h00, -1, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 18, 8'h80, 8'h03, 8'h00, -1, 1'b0, 1'b0};
    tbl[6] = '{8'h03, 1,  8'h77, 8'h00, 8'h00, -1, 1'b0, 1'b1};
    tbl[7] = '{8'h02, 6,  8'hC0, 8'h07, 8'h00, 4,  1'b1, 1'b0};

    rst = 1;
    repeat (3) @(negedge clk);
    check_reset_vals("init");
    rst = 0;
    @(negedge clk);

    // partial frame, reset after five data bytes, then a fresh frame from address 0
    fb = {8'h00, 8'd10, 8'h00, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    host(fb, -1, 1'b0, 8);
    chk("pre_rst_byte_count", byte_count == 16'd5, byte_count, 5);
    chk("pre_rst_mem_addr", mem_addr == AW'(5), mem_addr, 5);
    rst = 1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 0;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      d = {};
      for (int i = 0; i < tbl[t].n; i++) d.push_back(8'(tbl[t].d0 + tbl[t].step * i));
      run_frame(tbl[t].tgt, d, tbl[t].cdelta, tbl[t].coinc, tbl[t].sbusy, tbl[t].exp_err);
    end

    for (int r = 0; r < 12; r++) begin
      logic [7:0] tgt, cdelta;
      int n, coinc;
      tgt = 8'($urandom_range(0, 4));
      n = $urandom_range(0, 20);
      d = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
      cdelta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      coinc = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(3, 2 + n) : -1;
      run_frame(tgt, d, cdelta, coinc, 1'($urandom_range(0, 1)),
                (int'(tgt) >= NT) || (CS && cdelta != 8'h00));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

Parametrised UART-driven memory loader that sits between the `uart` core and the VDP memories (VRAM, CRAM, register file). It runs the existing request/echo byte protocol: every transmitted byte acknowledges the previous received byte and requests the next. It also parses a framed header carrying a target-memory index and a byte count, so one block can fill any of `NUM_TARGETS` memories through a one-hot write-enable vector. Receive and transmit-complete events are captured synchronously; the block has no asynchronous latches.

## Interface
- `ADDR_W`, default 14: width of `mem_addr`. Addresses wrap modulo 2^ADDR_W.
- `NUM_TARGETS`, default 3: number of write-enable lanes. Index 0 = VRAM, 1 = CRAM, 2 = VDP registers.
- `REQ_BYTE`, default 8'h00: byte sent on the first request of a frame.
- `clk` in 1: system clock (vga_clk domain). One clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: level; sampled only in IDLE.
- `rx_data` in 8: received byte, valid while `rx_done` is high.
- `rx_done` in 1: one-cycle pulse from the UART.
- `tx_done` in 1: one-cycle pulse from the UART.
- `tx_data` out 8: byte to transmit. Held stable from `tx_wr` until `tx_done`.
- `tx_wr` out 1: one-cycle transmit strobe.
- `mem_addr` out ADDR_W: write address.
- `mem_data` out 8: write data.
- `mem_we` out NUM_TARGETS: one-hot write strobe, high for one cycle per byte.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `err` out 1: sticky error flag. Cleared by `rst` or by a new `start`.
- `byte_count` out 16: data bytes written in the current frame.

## Operation
- Frame format, in order:
  - `target` (1 byte)
  - `len_lo`, `len_hi` (16-bit N = number of data bytes)
  - N data bytes
  - `csum` (only with `LOADER_CHECKSUM_EN`)
- States: IDLE, REQ, WAIT_TX, WAIT_RX, HDR, WRITE, DONE.
- IDLE:
  - On `start`=1: go to REQ, set `tx_data`=REQ_BYTE, clear `err`, clear `byte_count`, set `mem_addr`=0.
- REQ:
  - Assert `tx_wr` for one cycle, clear `rx_pend`, go to WAIT_TX.
- WAIT_TX:
  - Leave on `tx_done`. If the frame is complete, go to DONE; otherwise go to WAIT_RX.
- WAIT_RX:
  - On `rx_pend`: capture the byte into `tx_data` (echo).
  - Go to HDR for the header bytes or the trailing checksum; go to WRITE for data bytes.
- HDR:
  - Store `target` / `len_lo` / `len_hi` / compare `csum`, then go to REQ.
  - If `target` ≥ NUM_TARGETS: set `err`. Data bytes are still consumed and echoed, but `mem_we` stays 0.
- WRITE:
  - `mem_we[target]`=1 with `mem_data`=byte, then go to REQ.
  - On leaving WRITE: `mem_addr`+1 (wraps), `byte_count`+1.
- N=0: after `len_hi` is echoed, go straight to the trailer (if enabled) or to DONE.
- DONE: pulse `done` for one cycle, go to IDLE.
- `rx_pend` register:
  - Set by `rx_done`.
  - Cleared in REQ.
  - If `rx_done` and the REQ clear occur in the same cycle, set wins.
  - `rx_data` is captured into a holding register on `rx_done`.
- `start` while `busy`: ignored.
- `rst` mid-frame: returns to IDLE next edge. The partially written memory is not rolled back.

## Timing
- Reset values: `tx_data`=0, `tx_wr`=0, `mem_addr`=0, `mem_data`=0, `mem_we`=0, `busy`=0, `done`=0, `err`=0, `byte_count`=0. State = IDLE.
- `start` high at cycle t: `tx_wr`=1 during t+2.
- `rx_done` at cycle t, block in WAIT_RX:
  - `rx_pend`=1 at t+1.
  - `mem_we` high during t+2 (data byte).
  - `tx_wr` high during t+3.
- `mem_addr`/`mem_data` are stable for the whole cycle `mem_we` is high. The address increments on the following edge.
- `done` is asserted the cycle after the `tx_done` that completes the final echo. `busy` falls on the same edge that `done` falls.
- Throughput is bounded by the UART round trip; the block adds 3 cycles per byte.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The frame carries a trailing `csum` byte, which is echoed like any other byte.
  - Required value: the 8-bit sum (mod 256) of all N data bytes.
  - On mismatch, `err`=1 at `done`. Memory is already written.
- Not defined:
  - No trailer. The frame ends after the last data byte's echo.
  - `err` is set only by a bad target.

## Test plan
- Reset mid-frame after 5 data bytes -> all outputs take their reset values next cycle; a fresh `start` reloads from `mem_addr`=0.
- `start`; host sends 00,04,00,11,22,33,44 (+csum AA if enabled) -> `mem_we`=3'b001 at addrs 0..3 with data 11,22,33,44; echoes REQ_BYTE then each byte in order; `done` pulse; `err`=0; `byte_count`=4.
- Target 05, N=2, data 01 02 -> both bytes echoed, `mem_we` never asserted, `err`=1, `done` pulses.
- `LOADER_CHECKSUM_EN` defined; target 01, N=3, data 10 20 30, csum 61 -> CRAM written at addrs 0..2, `err`=1; with csum 60, `err`=0.
- N=0 -> no `mem_we`, three header echoes, `done`; with ADDR_W=4 and N=18 -> addrs 0..15, 0, 1 (wrap).
- `rx_done` coincident with the REQ-cycle clear -> byte is not lost, written on the next WAIT_RX; `start` pulsed while busy -> no effect.
